// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle sequencer for the RV32 M-extension operations
// (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the EX-stage ALU
// and stalls the pipeline until its registered result is ready for writeback.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   EX-stage M-extension instruction valid (sampled only in IDLE)
//   funct3  operation select (000 MUL ... 111 REMU)
//   op_a    rs1 value (dividend / multiplicand)
//   op_b    rs2 value (divisor / multiplier)
//   flush   pipeline flush, kills any operation in flight
//   stall   hold IF/ID/EX registers
//   busy    sequencer is not idle
//   done    one-cycle pulse, result valid for writeback
//   result  registered result, held until the next completion
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [4:0]      count;
    logic            neg_quot_q;
    logic            neg_rem_q;

    logic            accept;
    logic            signed_div;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_result;

    logic              a_sext;
    logic              b_sext;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quot_step;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_result;

    assign accept = (state == IDLE) && start && !flush;
    assign stall  = accept || (state == MUL) || (state == DIV);
    assign busy   = (state != IDLE);
    // A flush on the done cycle suppresses the writeback pulse.
    assign done   = (state == DONE) && !flush;

    // Operand classification for the divide family; funct3[0]=0 means signed.
    assign signed_div = ~funct3[0];
    assign a_neg      = signed_div & op_a[XLEN-1];
    assign b_neg      = signed_div & op_b[XLEN-1];
    assign a_mag      = a_neg ? -op_a : op_a;
    assign b_mag      = b_neg ? -op_b : op_b;
    assign div_zero   = (op_b == '0);
    assign div_ovf    = signed_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special    = funct3[2] & (div_zero | div_ovf);

    // RISC-V defined results for divide-by-zero and signed overflow.
    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = funct3[1] ? op_a : '1;
        end else begin
            special_result = funct3[1] ? '0 : op_a;
        end
    end

    // Sign-extending straight to 64 bits gives the same low 64 product bits
    // as a 33x33 signed multiply, so no wider result is needed.
    assign a_sext  = (op_q == 2'b01) || (op_q == 2'b10);
    assign b_sext  = (op_q == 2'b01);
    assign mul_a   = {{XLEN{a_sext & a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{XLEN{b_sext & b_q[XLEN-1]}}, b_q};
    assign product = mul_a * mul_b;

    // One restoring step: the dividend shifts out of quot_q MSB-first while
    // quotient bits shift in at the bottom.
    assign rem_shift  = {rem_q, quot_q[XLEN-1]};
    assign diff       = rem_shift - {1'b0, b_q};
    assign quot_step  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    assign rem_step   = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_fix   = neg_quot_q ? -quot_step : quot_step;
    assign rem_fix    = neg_rem_q ? -rem_step : rem_step;
    assign div_result = op_q[1] ? rem_fix : quot_fix;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!funct3[2]) begin
                        state_next = MUL;
                    end else if (special) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL:     state_next = DONE;
            DIV:     if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath: operand capture, divide iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            count      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= funct3[1:0];
                        a_q        <= op_a;
                        b_q        <= funct3[2] ? b_mag : op_b;
                        quot_q     <= a_mag;
                        rem_q      <= '0;
                        count      <= '0;
                        neg_quot_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        if (special) begin
                            result <= special_result;
                        end
                    end
                end
                MUL: begin
                    result <= (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                end
                DIV: begin
                    quot_q <= quot_step;
                    rem_q  <= rem_step;
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= div_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Directed cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          errors;
    logic [31:0] last_res;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference result straight from the RISC-V M-extension rules.
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        logic [31:0]     r;
        r = '0;
        case (f3)
            3'b000: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
            3'b001: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
            3'b010: begin p = longint'($signed(a)) * longint'({32'h0, b}); r = p[63:32]; end
            3'b011: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = longint'($signed(a)) / longint'($signed(b)); r = p[31:0]; end
            end
            3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else begin p = longint'($signed(a)) % longint'($signed(b)); r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycle index of the done pulse, counting the start cycle as 0.
    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
        return 33;
    endfunction

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        start  = s;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        flush  = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one operation from an IDLE cycle and follow it to its done pulse.
    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stall_bad;
        lat       = 0;
        stall_bad = 0;
        applyStimulus(1'b1, f3, a, b, 1'b0);
        @(negedge clk);
        while (done !== 1'b1 && lat < 60) begin
            if (stall !== 1'b1) stall_bad++;
            nextCycle;
            applyStimulus(1'b0, f3, a, b, 1'b0);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_stall_on_done"}, {31'b0, stall}, 32'h0);
        checkOutput({tag, "_stall_while_busy"}, stall_bad, 32'h0);
        last_res = exp_res;
        nextCycle;
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rsel;
        int          done_cnt;

        checks   = 0;
        errors   = 0;
        last_res = '0;
        clk      = 1'b0;
        rst      = 1'b1;
        applyStimulus(1'b1, 3'b000, 32'd5, 32'd6, 1'b0);

        // Two reset cycles with start held high: nothing may be captured.
        nextCycle;
        nextCycle;
        rst = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("reset_stall", {31'b0, stall}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        checkOutput("reset_result", result, 32'h0);
        nextCycle;
        @(negedge clk);
        checkOutput("start_in_reset_busy", {31'b0, busy}, 32'h0);
        nextCycle;

        // Multiply family.
        runOp("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        runOp("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2);
        runOp("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        runOp("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);

        // Divide family, normal path.
        runOp("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        runOp("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        runOp("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        runOp("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Special path.
        runOp("divu_by_zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        runOp("rem_by_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        runOp("div_overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp("rem_overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

        // Restore a known non-zero result before the flush test.
        runOp("divu_pre_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Flush in DIV cycle 10.
        done_cnt = 0;
        applyStimulus(1'b1, 3'b101, 32'd1000, 32'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            nextCycle;
            applyStimulus(1'b0, 3'b101, 32'd1000, 32'd3, c == 10);
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        nextCycle;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        checkOutput("flush_busy", {31'b0, busy}, 32'h0);
        checkOutput("flush_stall", {31'b0, stall}, 32'h0);
        checkOutput("flush_no_done", done_cnt, 32'h0);
        checkOutput("flush_result_held", result, last_res);
        nextCycle;
        runOp("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2);

        // start held high through DONE: one pulse, then re-accept in IDLE.
        done_cnt = 0;
        applyStimulus(1'b1, 3'b000, 32'd5, 32'd6, 1'b0);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (c == 3) begin
                checkOutput("held_single_done", done_cnt, 32'd1);
                checkOutput("held_reaccept_stall", {31'b0, stall}, 32'h1);
                checkOutput("held_reaccept_idle", {31'b0, busy}, 32'h0);
            end
            if (c == 5) begin
                checkOutput("held_second_done", {31'b0, done}, 32'h1);
                checkOutput("held_second_result", result, 32'd30);
            end
            nextCycle;
            if (c == 3) start = 1'b0;
        end
        last_res = 32'd30;

        // Flush together with start in IDLE: nothing accepted.
        applyStimulus(1'b1, 3'b000, 32'd9, 32'd9, 1'b1);
        @(negedge clk);
        checkOutput("flush_start_stall", {31'b0, stall}, 32'h0);
        nextCycle;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("flush_start_busy", {31'b0, busy}, 32'h0);
        checkOutput("flush_start_result", result, last_res);
        nextCycle;

        // Reset in the middle of a divide.
        applyStimulus(1'b1, 3'b100, 32'd100, 32'd7, 1'b0);
        nextCycle;
        applyStimulus(1'b0, 3'b100, 32'd100, 32'd7, 1'b0);
        nextCycle;
        nextCycle;
        rst = 1'b1;
        nextCycle;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midop_reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("midop_reset_done", {31'b0, done}, 32'h0);
        checkOutput("midop_reset_result", result, 32'h0);
        nextCycle;

        // Randomized operations, biased toward the divide corner cases.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rf3  = 3'($urandom_range(0, 7));
            rsel = $urandom_range(0, 9);
            if (rsel == 0) begin
                rb = 32'h0;
            end else if (rsel == 1) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end else if (rsel == 2) begin
                rb = rb >> $urandom_range(0, 31);
            end
            runOp($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, refResult(rf3, ra, rb), refLatency(rf3, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
